// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// fifo_arb_pkg -- shared defaults, counter width helper and FSM type for fifo_rr_arbiter (rev 1.0)
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_DEF   = 8;

  // Occupancy needs to represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_w(DEPTH_DEF);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rr_arbiter_rr_pick.sv
`default_nettype none
// rr_pick -- combinational round-robin picker: first set bit of req at or after ptr, wrapping (rev 1.0)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[PTR_W'((int'(ptr) + k) % NUM_REQ)]) begin
        grant = '0;
        grant[PTR_W'((int'(ptr) + k) % NUM_REQ)] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// fifo_rr_arbiter -- round-robin N-to-1 write arbiter with occupancy tracking for a FIFO (rev 1.0)
// Optional macro FIFO_RR_ARB_LOCK_EN adds req_lock and the LOCKED burst state.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef FIFO_RR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic                      write_en,
  output logic [DATA_W-1:0]         write_data,
  output logic                      read_en,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_t         state, state_nxt;
  logic [PW-1:0]      rr_ptr, nxt_ptr, gidx;
  logic [NUM_REQ-1:0] mask, lock_mask, pick, grant;
  logic [DATA_W-1:0]  gdata;
  logic               rd_acc, wr_ok, wr_acc;

`ifdef FIFO_RR_ARB_LOCK_EN
  logic [PW-1:0] lock_idx;
  logic [CW-1:0] lock_cnt;
  assign lock_mask = req_valid & (NUM_REQ'(1) << lock_idx);
`else
  assign lock_mask = '0;
`endif

  // Only requester-valid bits feed the picker, so req_ready never depends on req_data.
  assign mask   = (state == ARB) ? req_valid : lock_mask;
  assign rd_acc = !rst && rd_req && ((count != '0) || (|mask));
  assign wr_ok  = !rst && ((count < DEPTH_C) || rd_acc);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_pick (
    .req   (mask),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  assign grant     = wr_ok ? pick : '0;
  assign wr_acc    = |grant;
  assign req_ready = grant;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
      gdata = gdata | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
    end
  end

  assign nxt_ptr = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  always_comb begin
`ifdef FIFO_RR_ARB_LOCK_EN
    state_nxt = state;
    case (state)
      ARB: begin
        if (wr_acc && (|(grant & req_lock)) && (DEPTH > 1)) state_nxt = LOCKED;
      end
      LOCKED: begin
        // The DEPTH-th consecutive accept (entry accept included) ends the burst.
        if (!req_lock[lock_idx] || !req_valid[lock_idx] ||
            (wr_acc && (lock_cnt == DEPTH_C - 1'b1)))
          state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
`else
    state_nxt = ARB;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      count      <= '0;
      write_en   <= 1'b0;
      read_en    <= 1'b0;
      rd_ack     <= 1'b0;
      write_data <= '0;
    end else begin
      state    <= state_nxt;
      write_en <= wr_acc;
      read_en  <= rd_acc;
      rd_ack   <= rd_acc;
      if (wr_acc) begin
        write_data <= gdata;
        rr_ptr     <= nxt_ptr;
      end
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (!wr_acc && rd_acc) count <= count - 1'b1;
    end
  end

`ifdef FIFO_RR_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_idx <= '0;
      lock_cnt <= '0;
    end else if (state == ARB) begin
      if (state_nxt == LOCKED) begin
        lock_idx <= gidx;
        lock_cnt <= CW'(1);
      end
    end else if (wr_acc) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
